// File: rtl/gate_exer_pkg.sv
// gate_exer_pkg: shared FSM state type, vector count and common 2-input truth tables
package gate_exer_pkg;
    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_SAMPLE, S_DONE} gate_exer_state_t;
    localparam int NUM_VECTORS = 4;
    localparam logic [3:0] AND_TABLE  = 4'b1000;
    localparam logic [3:0] OR_TABLE   = 4'b1110;
    localparam logic [3:0] XOR_TABLE  = 4'b0110;
    localparam logic [3:0] NAND_TABLE = 4'b0111;
endpackage

// File: rtl/gate_exer_settle_timer.sv
// gate_exer_settle_timer: loadable down-counter with zero flag
//   clk, rst (async, active-high), load/value: preset the count, zero: count has reached 0.
//   Counts down by one each cycle when not loading and stops at 0.
module gate_exer_settle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);
    logic [W-1:0] count;
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (load) count <= value;
        else if (count != '0) count <= count - W'(1);
    assign zero = count == '0;
endmodule

// File: rtl/gate_exerciser.sv
// gate_exerciser: self-test engine applying all four {a,b} vectors to a 2-input gate
//   clk, rst (async, active-high); start: run request sampled in IDLE; gate_y: gate output.
//   gate_a/gate_b: gate drive; busy: not IDLE; done: one-cycle end-of-run pulse;
//   pass: last run had no mismatch; err_count: saturating mismatch count;
//   fail_vec: bit i set if vector {a,b}=i mismatched.
//   Optional macro GATE_EXER_CONT_EN: start high at the last sample restarts the vector
//   sweep without passing DONE, accumulating errors across passes.
module gate_exerciser
    import gate_exer_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] EXP_TABLE     = AND_TABLE,
    parameter int         CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             gate_y,
    output logic             gate_a,
    output logic             gate_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [3:0]       fail_vec
);
    localparam int TW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    // The timer is loaded in DRIVE and SETTLE exits on zero, so load N-1 for N settle cycles.
    localparam logic [TW-1:0] LOAD = TW'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    gate_exer_state_t state;
    logic [1:0] idx;
    logic t_zero, miss, wrap;

    gate_exer_settle_timer #(.W(TW)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (state == S_DRIVE),
        .value(LOAD),
        .zero (t_zero)
    );

    assign miss = gate_y != EXP_TABLE[idx];
`ifdef GATE_EXER_CONT_EN
    assign wrap = start;
`else
    assign wrap = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            gate_a    <= 1'b0;
            gate_b    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE:
                    if (start) begin
                        state     <= S_DRIVE;
                        busy      <= 1'b1;
                        idx       <= '0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        fail_vec  <= '0;
                    end
                S_DRIVE: begin
                    state  <= SETTLE_CYCLES == 0 ? S_SAMPLE : S_SETTLE;
                    gate_a <= idx[1];
                    gate_b <= idx[0];
                end
                S_SETTLE:
                    if (t_zero) state <= S_SAMPLE;
                S_SAMPLE: begin
                    if (miss) begin
                        fail_vec[idx] <= 1'b1;
                        if (err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);
                    end
                    // idx is two bits wide, so the increment after vector 3 wraps to 0.
                    if (idx != 2'd3 || wrap) begin
                        idx   <= idx + 2'd1;
                        state <= S_DRIVE;
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    pass   <= err_count == '0;
                    gate_a <= 1'b0;
                    gate_b <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
endmodule
